// File: rtl/imem_loader.sv
// imem_loader: boot loader that receives a framed UART byte stream, writes big-endian
// words into imem, verifies the payload checksum and releases processor reset on success.
module imem_loader #(
    parameter int          ADDR_W  = 12,
    parameter int          TIMEOUT = 100000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              proc_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       word_count
);
    localparam int          TW  = $clog2(TIMEOUT + 1);
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {IDLE, CNT_H, CNT_L, DATA, CSUM, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         wc_q, wc_d;
    logic [1:0]          idx_q, idx_d;
    logic [7:0]          sum_q, sum_d;
    logic [23:0]         asm_q, asm_d;
    logic [TW-1:0]       idle_q, idle_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                timing;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wc_d    = wc_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        asm_d   = asm_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        timing  = state_q inside {CNT_H, CNT_L, DATA, CSUM};
        idle_d  = (rx_valid || !timing) ? '0 : idle_q + 1'b1;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (rx_valid && rx_data == SYNC) begin
                    state_d = CNT_H;
                    wc_d    = '0;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            CNT_H: begin
                if (rx_valid) begin
                    cnt_d   = {rx_data, 8'h00};
                    state_d = CNT_L;
                end
            end
            CNT_L: begin
                if (rx_valid) begin
                    cnt_d   = {cnt_q[15:8], rx_data};
                    state_d = ({1'b0, cnt_d} > CAP) ? ERR : (cnt_d == 16'd0) ? CSUM : DATA;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    sum_d = sum_q + rx_data;
                    asm_d = {asm_q[15:0], rx_data};
                    idx_d = idx_q + 1'b1;
                    // fourth byte completes a word: register the write pulse for next cycle
                    if (idx_q == 2'd3) begin
                        wren_d  = 1'b1;
                        wdata_d = {asm_q, rx_data};
                        addr_d  = wc_q[ADDR_W-1:0];
                        wc_d    = wc_q + 1'b1;
                        if (wc_d == cnt_q) state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (rx_valid) state_d = (rx_data == sum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
        if (timing && !rx_valid && idle_q == TW'(TIMEOUT - 1)) state_d = ERR;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wc_q    <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            asm_q   <= '0;
            idle_q  <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wc_q    <= wc_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            asm_q   <= asm_d;
            idle_q  <= idle_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_wren  = wren_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign proc_reset = state_q != DONE;
    assign load_done  = state_q == DONE;
    assign load_error = state_q == ERR;
    assign word_count = wc_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the processor's instruction memory.
- Receives a framed byte stream from the UART receiver and assembles big-endian 32-bit words.
- Writes each word into imem through the imem write port, validates an 8-bit checksum, and holds the processor in reset until a good image is loaded.
- Sits between the UART RX block and the imem write port / processor reset input in the Wrapper.

Parameters:
- ADDR_W, 12, imem word-address width; capacity is 2**ADDR_W words.
- TIMEOUT, 100000, maximum idle cycles between bytes inside a frame before aborting.
- SYNC, 8'hA5, frame start byte.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- imem_wren  out  1  imem write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  imem word address being written.
- imem_wdata  out  32  word being written.
- proc_reset  out  1  active-high reset to the processor; high whenever not in DONE.
- load_done  out  1  high in DONE.
- load_error  out  1  high in ERR.
- word_count  out  16  number of words written in the current or last frame.

Behaviour:
- Frame format: SYNC, CNT_HI, CNT_LO, then N = {CNT_HI, CNT_LO} words of 4 bytes each (MSB first), then CSUM. CSUM is the 8-bit modulo-256 sum of all payload bytes only (header excluded).
- States and transitions:
  - IDLE: bytes other than SYNC are ignored; SYNC -> CNT_H.
  - CNT_H: capture high count byte -> CNT_L.
  - CNT_L: capture low byte. N > 2**ADDR_W -> ERR. N == 0 -> CSUM. Otherwise -> DATA.
  - DATA: 2-bit byte index shifts bytes into a 32-bit assembly register (byte0 -> [31:24]).
    - On the 4th byte, the next cycle: imem_wren=1, imem_wdata=assembled word, imem_addr=word index; word index and word_count then increment.
    - After the N-th word's 4th byte -> CSUM.
  - CSUM: received byte == running sum -> DONE, else ERR.
  - DONE: proc_reset=0, load_done=1. A SYNC byte restarts the load (-> CNT_H, proc_reset=1 the next cycle). Other bytes are ignored.
  - ERR: proc_reset=1, load_error=1. A SYNC byte restarts the load; other bytes are ignored.
- Restart from IDLE, DONE or ERR clears the word index, word_count, byte index, running sum, load_done and load_error.
- Timeout: an idle counter runs in CNT_H, CNT_L, DATA and CSUM, cleared on each rx_valid. When it reaches TIMEOUT-1 without a byte -> ERR. The counter does not run in IDLE, DONE or ERR.
- A SYNC value received inside a frame is treated as data, not as a restart.
- The imem write of the last word happens in the cycle after its 4th byte, regardless of whether a CSUM byte arrives in that same cycle; both events are handled.
- Because the write is a registered pulse, at most one write per cycle. rx_valid can be asserted back-to-back every cycle with no byte lost.
- Reset (asserted low, asynchronous, any state including mid-frame): state=IDLE, imem_wren=0, imem_addr=0, imem_wdata=0, proc_reset=1, load_done=0, load_error=0, word_count=0, all internal counters 0. Partially written imem contents are not cleared.
- imem_addr wraps are impossible: N is bounded by the CNT_L check.

Test Plan:
- Good frame: A5 00 02 | 00 00 00 05 | 12 34 56 78 | CSUM=0x19 -> writes (addr0, 0x00000005) and (addr1, 0x12345678). Then load_done=1, proc_reset=0, word_count=2.
- Bad checksum: same frame with CSUM=0x18 -> both words written, then load_error=1 and proc_reset stays 1.
- Zero length: A5 00 00 00 -> DONE, no imem_wren pulse, word_count=0.
- Oversize: with ADDR_W=4, send A5 00 11 -> ERR immediately after CNT_LO, no writes.
- Timeout: with TIMEOUT=16, send A5 00 01 AA, then idle 16 cycles -> ERR. Then send the full good one-word frame A5 00 01 AA BB CC DD CSUM=0x0E -> DONE, word 0xAABBCCDD at addr 0.
- Back-to-back and reset: stream bytes every cycle; assert reset low mid-DATA -> all outputs at reset values immediately. Leftover bytes other than A5 are ignored in IDLE, and a fresh frame then loads correctly.
